mul_div_unit: RTL and testbench

Iterative multiply/divide unit in the execute stage. Consumes o_SrcAE/o_SrcBE and the mul/div decode from the decode-to-execute register. Implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers, plus MTHI/MTLO writes. o_Busy feeds the hazard unit, which stalls MFHI/MFLO and any new mul/div until the unit is idle.

---
 rtl/mul_div_unit_if.sv | 31 +++
 rtl/mul_div_unit.sv | 142 ++++++++++++++
 tb/tb_mul_div_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Execute-stage bus into the iterative multiply/divide unit.
// Start handshake: i_Start is taken only on an edge where o_Busy is low and
// i_Abort is low. A start seen while o_Busy is high is dropped, not queued.
// o_Done pulses for one cycle once HI/LO hold the new result.
interface mul_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_Start;
    logic [1:0]            i_Op;
    logic [DATA_WIDTH-1:0] i_SrcAE;
    logic [DATA_WIDTH-1:0] i_SrcBE;
    logic                  i_MTHI;
    logic                  i_MTLO;
    logic                  i_Abort;
    logic [DATA_WIDTH-1:0] o_HI;
    logic [DATA_WIDTH-1:0] o_LO;
    logic                  o_Busy;
    logic                  o_Done;

    // Pipeline side: drives requests and reads HI/LO.
    modport master (
        output i_Start, i_Op, i_SrcAE, i_SrcBE, i_MTHI, i_MTLO, i_Abort,
        input  o_HI, o_LO, o_Busy, o_Done
    );

    // Unit side.
    modport slave (
        input  i_Start, i_Op, i_SrcAE, i_SrcBE, i_MTHI, i_MTLO, i_Abort,
        output o_HI, o_LO, o_Busy, o_Done
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO.
// Ops: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. One step per cycle, DATA_WIDTH
// steps, then a single fix-up cycle that applies signs and writes HI/LO.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    mul_div_unit_if.slave    bus
);

    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [1:0]            op_q;       // [1]=divide, [0]=signed
    logic [DW-1:0]         opnd_q;     // multiplicand (mul) or divisor (div) magnitude
    logic [DW-1:0]         a_raw_q;    // dividend as latched, for divide-by-zero HI
    logic [2*DW-1:0]       acc_q;      // {hi, lo} product or {remainder, quotient}
    logic                  neg_res_q;  // operand signs differ on a signed op
    logic                  neg_a_q;    // dividend negative on a signed op
    logic [DW-1:0]         hi_q;
    logic [DW-1:0]         lo_q;
    logic                  done_q;

    logic [DW-1:0]         mag_a_d;
    logic [DW-1:0]         mag_b_d;
    logic [DW:0]           mul_sum_d;
    logic [DW:0]           div_sub_d;
    logic [2*DW-1:0]       step_d;
    logic [2*DW-1:0]       prod_d;
    logic [DW-1:0]         hi_d;
    logic [DW-1:0]         lo_d;

    // Operand magnitudes for a start request: signed ops take absolute values.
    always_comb begin
        mag_a_d = bus.i_SrcAE;
        mag_b_d = bus.i_SrcBE;
        if (bus.i_Op[0] && bus.i_SrcAE[DW-1]) mag_a_d = -bus.i_SrcAE;
        if (bus.i_Op[0] && bus.i_SrcBE[DW-1]) mag_b_d = -bus.i_SrcBE;
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum_d = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_sub_d = acc_q[2*DW-1:DW-1] - {1'b0, opnd_q};
        if (!op_q[1]) begin
            step_d = {mul_sum_d, acc_q[DW-1:1]};
        end else if (div_sub_d[DW]) begin
            step_d = {acc_q[2*DW-2:0], 1'b0};
        end else begin
            step_d = {div_sub_d[DW-1:0], acc_q[DW-2:0], 1'b1};
        end
    end

    // Sign fix-up and final HI/LO values, including the divide-by-zero result.
    always_comb begin
        prod_d = neg_res_q ? -acc_q : acc_q;
        hi_d   = prod_d[2*DW-1:DW];
        lo_d   = prod_d[DW-1:0];
        if (op_q[1]) begin
            if (opnd_q == '0) begin
                hi_d = a_raw_q;
                lo_d = '1;
            end else begin
                lo_d = neg_res_q ? -acc_q[DW-1:0] : acc_q[DW-1:0];
                hi_d = neg_a_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];
            end
        end
    end

    // Control FSM with datapath registers and registered HI/LO/done.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_MTHI) hi_q <= bus.i_SrcAE;
                    if (bus.i_MTLO) lo_q <= bus.i_SrcAE;
                    if (bus.i_Start && !bus.i_Abort) begin
                        state_q   <= ST_CALC;
                        cnt_q     <= '0;
                        op_q      <= bus.i_Op;
                        a_raw_q   <= bus.i_SrcAE;
                        neg_res_q <= bus.i_Op[0] & (bus.i_SrcAE[DW-1] ^ bus.i_SrcBE[DW-1]);
                        neg_a_q   <= bus.i_Op[0] & bus.i_SrcAE[DW-1];
                        if (bus.i_Op[1]) begin
                            opnd_q <= mag_b_d;
                            acc_q  <= {{DW{1'b0}}, mag_a_d};
                        end else begin
                            opnd_q <= mag_a_d;
                            acc_q  <= {{DW{1'b0}}, mag_b_d};
                        end
                    end
                end
                ST_CALC: begin
                    if (bus.i_Abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= step_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_WIDTH'(DW - 1)) state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    if (!bus.i_Abort) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_HI   = hi_q;
    assign bus.o_LO   = lo_q;
    assign bus.o_Busy = (state_q != ST_IDLE);
    assign bus.o_Done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic vectors, latency/done pulse,
// abort, ignored requests while busy, and asynchronous reset mid-operation.
module tb_mul_div_unit;

    logic i_CLK;
    logic i_RST;
    int   checks;
    int   failures;

    mul_div_unit_if #(.DATA_WIDTH(32)) bus ();

    mul_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .bus   (bus.slave)
    );

    // Clock: 10 ns period.
    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_Start = 1'b0;
        bus.i_Op    = 2'b00;
        bus.i_SrcAE = '0;
        bus.i_SrcBE = '0;
        bus.i_MTHI  = 1'b0;
        bus.i_MTLO  = 1'b0;
        bus.i_Abort = 1'b0;
    endtask

    // Issue one op from a negedge, then watch 60 cycles: busy must be high for
    // 33 cycles, done must pulse once, and HI/LO must hold the expected result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int busy_cycles;
        int done_cycles;
        bus.i_Start = 1'b1;
        bus.i_Op    = op;
        bus.i_SrcAE = a;
        bus.i_SrcBE = b;
        @(posedge i_CLK);
        #1;
        bus.i_Start = 1'b0;
        busy_cycles = 0;
        done_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_CLK);
            if (bus.o_Busy) busy_cycles++;
            if (bus.o_Done) done_cycles++;
        end
        check_val({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
        check_val({tag, "_done_pulses"}, 64'(done_cycles), 64'd1);
        check_val({tag, "_hi"}, 64'(bus.o_HI), 64'(exp_hi));
        check_val({tag, "_lo"}, 64'(bus.o_LO), 64'(exp_lo));
    endtask

    // Single-cycle MTHI/MTLO write from a negedge.
    task automatic mt_write(input logic hi_sel, input logic [31:0] val);
        bus.i_MTHI  = hi_sel;
        bus.i_MTLO  = ~hi_sel;
        bus.i_SrcAE = val;
        @(posedge i_CLK);
        #1;
        bus.i_MTHI = 1'b0;
        bus.i_MTLO = 1'b0;
        @(negedge i_CLK);
    endtask

    initial begin
        int busy_seen;
        int done_seen;
        checks   = 0;
        failures = 0;
        idle_inputs();
        i_RST = 1'b0;
        repeat (3) @(negedge i_CLK);
        check_val("reset_hi", 64'(bus.o_HI), 64'h0);
        check_val("reset_lo", 64'(bus.o_LO), 64'h0);
        check_val("reset_busy", 64'(bus.o_Busy), 64'h0);
        check_val("reset_done", 64'(bus.o_Done), 64'h0);
        i_RST = 1'b1;
        @(negedge i_CLK);

        // Arithmetic vectors.
        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg3x7", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("mult_min_sq", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        run_op("mult_5xneg4", 2'b01, 32'd5, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC);
        run_op("div_neg7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_neg2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
        run_op("divu_7_2", 2'b10, 32'd7, 32'd2, 32'h1, 32'h3);
        run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run_op("divu_by0", 2'b10, 32'd5, 32'd0, 32'h5, 32'hFFFFFFFF);
        run_op("div_by0_neg", 2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // Abort test: preload HI/LO, start, poke while busy, then abort.
        mt_write(1'b1, 32'h11);
        mt_write(1'b0, 32'h22);
        check_val("mthi_val", 64'(bus.o_HI), 64'h11);
        check_val("mtlo_val", 64'(bus.o_LO), 64'h22);
        bus.i_Start = 1'b1;
        bus.i_Op    = 2'b00;
        bus.i_SrcAE = 32'd3;
        bus.i_SrcBE = 32'd4;
        @(posedge i_CLK);
        #1;
        bus.i_Start = 1'b0;
        repeat (5) @(posedge i_CLK);
        @(negedge i_CLK);
        // Start and MTLO while busy must both be dropped.
        bus.i_Start = 1'b1;
        bus.i_Op    = 2'b00;
        bus.i_MTLO  = 1'b1;
        bus.i_SrcAE = 32'h99;
        bus.i_SrcBE = 32'd9;
        @(posedge i_CLK);
        #1;
        bus.i_Start = 1'b0;
        bus.i_MTLO  = 1'b0;
        repeat (3) @(posedge i_CLK);
        @(negedge i_CLK);
        check_val("busy_before_abort", 64'(bus.o_Busy), 64'h1);
        check_val("lo_mtlo_ignored", 64'(bus.o_LO), 64'h22);
        bus.i_Abort = 1'b1;
        @(posedge i_CLK);
        #1;
        bus.i_Abort = 1'b0;
        @(negedge i_CLK);
        check_val("abort_busy", 64'(bus.o_Busy), 64'h0);
        busy_seen = 0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_CLK);
            if (bus.o_Busy) busy_seen++;
            if (bus.o_Done) done_seen++;
        end
        check_val("abort_no_restart", 64'(busy_seen), 64'h0);
        check_val("abort_no_done", 64'(done_seen), 64'h0);
        check_val("abort_hi", 64'(bus.o_HI), 64'h11);
        check_val("abort_lo", 64'(bus.o_LO), 64'h22);

        // Abort in IDLE suppresses a coincident start.
        bus.i_Start = 1'b1;
        bus.i_Abort = 1'b1;
        bus.i_Op    = 2'b00;
        bus.i_SrcAE = 32'd2;
        bus.i_SrcBE = 32'd2;
        @(posedge i_CLK);
        #1;
        bus.i_Start = 1'b0;
        bus.i_Abort = 1'b0;
        @(negedge i_CLK);
        check_val("idle_abort_start", 64'(bus.o_Busy), 64'h0);

        // Asynchronous reset in the middle of a divide.
        bus.i_Start = 1'b1;
        bus.i_Op    = 2'b11;
        bus.i_SrcAE = 32'hFFFFFFF9;
        bus.i_SrcBE = 32'd2;
        @(posedge i_CLK);
        #1;
        bus.i_Start = 1'b0;
        repeat (20) @(posedge i_CLK);
        @(negedge i_CLK);
        check_val("pre_reset_busy", 64'(bus.o_Busy), 64'h1);
        i_RST = 1'b0;
        #1;
        check_val("rst_mid_busy", 64'(bus.o_Busy), 64'h0);
        check_val("rst_mid_hi", 64'(bus.o_HI), 64'h0);
        check_val("rst_mid_lo", 64'(bus.o_LO), 64'h0);
        @(negedge i_CLK);
        i_RST = 1'b1;
        @(negedge i_CLK);
        run_op("multu_after_rst", 2'b00, 32'd2, 32'd3, 32'h0, 32'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
